// File: rtl/video_pkg.sv
// Shared constants and fetch FSM state type for the video RAM port.
// VIDEO_BASE is the controller-side base address of the text buffer.
package video_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned DEPTH  = COLS * ROWS;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 5;

  localparam logic [15:0] VIDEO_BASE = 16'hF82F;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } fetch_state_e;

endpackage

// File: rtl/video_ram_dp.sv
// Simple dual-port RAM: one write port, one registered read port.
// VIDEO_RAM_WRITE_BYPASS_EN: same-address read/write returns the new data.
module video_ram_dp #(
  parameter int unsigned Depth = 2400,
  parameter int unsigned AddrW = 12,
  parameter int unsigned DataW = 16
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [DataW-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AddrW-1:0] i_raddr,
  output logic [DataW-1:0] o_rdata
);

  logic [DataW-1:0] r_mem [Depth];
  logic [DataW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_re) begin
`ifdef VIDEO_RAM_WRITE_BYPASS_EN
      if (i_we && (i_waddr == i_raddr)) begin
        r_rdata <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_raddr];
      end
`else
      r_rdata <= r_mem[i_raddr];
`endif
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/video_ram_port.sv
// Text-cell buffer written by the memory controller, streamed row by row to the
// character generator. Same-cycle read/write behaviour set by VIDEO_RAM_WRITE_BYPASS_EN.
module video_ram_port
  import video_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_video_ram_addr,
  input  logic [DATA_W-1:0] i_video_ram_data,
  input  logic              i_video_ram_we,
  input  logic              i_row_req,
  input  logic [ROW_W-1:0]  i_row_idx,
  output logic              o_row_busy,
  output logic [DATA_W-1:0] o_cell_data,
  output logic [COL_W-1:0]  o_cell_col,
  output logic              o_cell_valid,
  input  logic              i_cell_ready,
  output logic              o_row_done,
  output logic              o_oob_write
);

  fetch_state_e r_state, w_state_d;

  logic [ADDR_W-1:0] r_base, w_base_d;
  logic [COL_W-1:0]  r_ptr, w_ptr_d;

  // Read in flight: data sits in the RAM output register this cycle.
  logic              r_pend;
  logic [COL_W-1:0]  r_pend_col;

  logic              r_out_v, w_out_v_d;
  logic [DATA_W-1:0] r_out_data, w_out_data_d;
  logic [COL_W-1:0]  r_out_col, w_out_col_d;
  logic              r_skid_v, w_skid_v_d;
  logic [DATA_W-1:0] r_skid_data, w_skid_data_d;
  logic [COL_W-1:0]  r_skid_col, w_skid_col_d;

  logic              r_oob;
  logic              w_wr_en;
  logic              w_oob_hit;
  logic              w_pop;
  logic              w_issue;
  logic [1:0]        w_occ;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  assign w_oob_hit = i_video_ram_we && (i_video_ram_addr >= ADDR_W'(DEPTH));
  assign w_wr_en   = i_video_ram_we && !w_oob_hit;
  assign w_pop     = r_out_v && i_cell_ready;
  assign w_rd_addr = r_base + ADDR_W'(r_ptr);

  // Entries held after this cycle; a new read needs one slot left for its return.
  assign w_occ   = 2'(r_out_v) + 2'(r_skid_v) + 2'(r_pend) - 2'(w_pop);
  assign w_issue = (r_state == StFetch) && (w_occ < 2'd2);

  video_ram_dp #(
    .Depth (DEPTH),
    .AddrW (ADDR_W),
    .DataW (DATA_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr_en),
    .i_waddr (i_video_ram_addr),
    .i_wdata (i_video_ram_data),
    .i_re    (w_issue),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_out_v_d     = r_out_v;
    w_out_data_d  = r_out_data;
    w_out_col_d   = r_out_col;
    w_skid_v_d    = r_skid_v;
    w_skid_data_d = r_skid_data;
    w_skid_col_d  = r_skid_col;
    if (w_pop) begin
      if (r_skid_v) begin
        w_out_v_d     = 1'b1;
        w_out_data_d  = r_skid_data;
        w_out_col_d   = r_skid_col;
        w_skid_v_d    = r_pend;
        w_skid_data_d = w_rd_data;
        w_skid_col_d  = r_pend_col;
      end else begin
        w_out_v_d = r_pend;
        if (r_pend) begin
          w_out_data_d = w_rd_data;
          w_out_col_d  = r_pend_col;
        end
      end
    end else if (r_pend) begin
      if (!r_out_v) begin
        w_out_v_d    = 1'b1;
        w_out_data_d = w_rd_data;
        w_out_col_d  = r_pend_col;
      end else begin
        w_skid_v_d    = 1'b1;
        w_skid_data_d = w_rd_data;
        w_skid_col_d  = r_pend_col;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_base_d  = r_base;
    w_ptr_d   = r_ptr;
    unique case (r_state)
      StIdle: begin
        if (i_row_req) begin
          if (i_row_idx < ROW_W'(ROWS)) begin
            w_state_d = StFetch;
            w_base_d  = ADDR_W'(i_row_idx) * ADDR_W'(COLS);
            w_ptr_d   = '0;
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StFetch: begin
        if (w_issue) begin
          w_ptr_d = r_ptr + 1'b1;
          if (r_ptr == COL_W'(COLS - 1)) begin
            w_state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!w_out_v_d && !w_skid_v_d) begin
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_base      <= '0;
      r_ptr       <= '0;
      r_pend      <= 1'b0;
      r_pend_col  <= '0;
      r_out_v     <= 1'b0;
      r_out_data  <= '0;
      r_out_col   <= '0;
      r_skid_v    <= 1'b0;
      r_skid_data <= '0;
      r_skid_col  <= '0;
      r_oob       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_base      <= w_base_d;
      r_ptr       <= w_ptr_d;
      r_pend      <= w_issue;
      r_pend_col  <= r_ptr;
      r_out_v     <= w_out_v_d;
      r_out_data  <= w_out_data_d;
      r_out_col   <= w_out_col_d;
      r_skid_v    <= w_skid_v_d;
      r_skid_data <= w_skid_data_d;
      r_skid_col  <= w_skid_col_d;
      if (w_oob_hit) begin
        r_oob <= 1'b1;
      end
    end
  end

  assign o_row_busy   = (r_state == StFetch) || (r_state == StDrain);
  assign o_row_done   = (r_state == StDone);
  assign o_cell_valid = r_out_v;
  assign o_cell_data  = r_out_data;
  assign o_cell_col   = r_out_col;
  assign o_oob_write  = r_oob;

endmodule

// File: tb/tb_video_ram_port.sv
// Bench for video_ram_port: array model of the buffer, directed rows with random data
// and random consumer stalls.
module tb_video_ram_port;

  localparam int TB_COLS  = 80;
  localparam int TB_ROWS  = 30;
  localparam int TB_DEPTH = TB_COLS * TB_ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_we = 1'b0;
  logic        row_req = 1'b0;
  logic [4:0]  row_idx = '0;
  logic        cell_ready = 1'b0;
  logic        row_busy;
  logic [15:0] cell_data;
  logic [6:0]  cell_col;
  logic        cell_valid;
  logic        row_done;
  logic        oob_write;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] ref_mem [0:TB_DEPTH-1];

  video_ram_port dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_video_ram_addr (wr_addr),
    .i_video_ram_data (wr_data),
    .i_video_ram_we   (wr_we),
    .i_row_req        (row_req),
    .i_row_idx        (row_idx),
    .o_row_busy       (row_busy),
    .o_cell_data      (cell_data),
    .o_cell_col       (cell_col),
    .o_cell_valid     (cell_valid),
    .i_cell_ready     (cell_ready),
    .o_row_done       (row_done),
    .o_oob_write      (oob_write)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [15:0] data);
    wr_we   = 1'b1;
    wr_addr = addr[11:0];
    wr_data = data;
    tick();
    wr_we = 1'b0;
    if (addr < TB_DEPTH) ref_mem[addr] = data;
  endtask

  // pattern 0: random words, pattern 1: word = column index
  task automatic fill_row(input int r, input int pattern);
    for (int c = 0; c < TB_COLS; c++) begin
      write_word(r * TB_COLS + c, (pattern == 1) ? 16'(c) : 16'($urandom));
    end
  endtask

  // mode 0: ready held high, 1: ready toggles 1/0, 2: random ready.
  // coll_col >= 0 writes 0xAAAA to that cell in the cycle its read is issued (mode 0).
  // abort_at >= 0 pulses reset once that many cells have transferred.
  task automatic fetch_row(input int idx, input int mode, input int coll_col, input int abort_at);
    int          k = 0;
    int          ncells = 0;
    int          ndone = 0;
    int          nbusy = 0;
    int          first_k = -1;
    int          last_k = -1;
    int          done_k = -1;
    int          base;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_data = '0;
    logic [6:0]  prev_col = '0;
    logic        rdy;
    logic        busy_at1 = 1'b0;
    logic [15:0] coll_exp = '0;
    logic [15:0] exp_d;
    base    = idx * TB_COLS;
    row_req = 1'b1;
    row_idx = idx[4:0];
    tick();
    row_req = 1'b0;
    while (k < 2000 && done_k < 0) begin
      if (abort_at >= 0 && ncells == abort_at) begin
        rst        = 1'b1;
        cell_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_valid", 32'(cell_valid), 32'd0);
        chk("abort_busy", 32'(row_busy), 32'd0);
        chk("abort_done", 32'(row_done), 32'd0);
        repeat (4) begin
          tick();
          if (row_done || cell_valid || row_busy) ndone++;
        end
        chk("abort_quiet", ndone, 0);
        return;
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = ((k % 2) == 0);
      else rdy = 1'($urandom_range(0, 1));
      cell_ready = rdy;
      wr_we = 1'b0;
      if (k == coll_col) begin
`ifdef VIDEO_RAM_WRITE_BYPASS_EN
        coll_exp = 16'hAAAA;
`else
        coll_exp = ref_mem[base + k];
`endif
        wr_we   = 1'b1;
        wr_addr = 12'(base + k);
        wr_data = 16'hAAAA;
      end
      if (row_done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (k == 1) busy_at1 = row_busy;
      if (stall_prev) begin
        chk("stall_hold", {8'd0, cell_valid, cell_col, cell_data}, {8'd0, 1'b1, prev_col, prev_data});
      end
      if (cell_valid) begin
        if (first_k < 0) first_k = k;
        if (rdy) begin
          exp_d = (ncells == coll_col) ? coll_exp : ref_mem[(base + ncells) % TB_DEPTH];
          chk("cell", {9'd0, cell_col, cell_data}, {9'd0, 7'(ncells), exp_d});
          last_k = k;
          ncells++;
        end
      end
      stall_prev = cell_valid && !rdy;
      prev_col   = cell_col;
      prev_data  = cell_data;
      tick();
      k++;
    end
    wr_we      = 1'b0;
    cell_ready = 1'b0;
    if (coll_col >= 0) ref_mem[base + coll_col] = 16'hAAAA;
    chk("row_cells", ncells, TB_COLS);
    chk("done_after_last", done_k, last_k + 1);
    if (mode == 0) begin
      chk("first_valid_k", first_k, 2);
      chk("last_valid_k", last_k, TB_COLS + 1);
      chk("busy_at1", 32'(busy_at1), 32'd1);
    end
    repeat (3) begin
      if (row_done) ndone++;
      if (row_busy || cell_valid) nbusy++;
      tick();
    end
    chk("done_pulses", ndone, 1);
    chk("idle_after_row", nbusy, 0);
  endtask

  initial begin
    int r;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(row_busy), 32'd0);
    chk("rst_valid", 32'(cell_valid), 32'd0);
    chk("rst_done", 32'(row_done), 32'd0);
    chk("rst_data_col", {9'd0, cell_col, cell_data}, 32'd0);
    chk("rst_oob", 32'(oob_write), 32'd0);
    rst = 1'b0;
    tick();

    // Row 0 with two known cells, streamed at full rate.
    fill_row(0, 0);
    write_word(0, 16'h0759);
    write_word(79, 16'h1234);
    fill_row(29, 1);
    fill_row(5, 0);
    chk("oob_clear_after_legal_writes", 32'(oob_write), 32'd0);
    fetch_row(0, 0, -1, -1);

    // Row 29 with a consumer that stalls every other cycle.
    fetch_row(29, 1, -1, -1);

    // Out-of-range writes must not disturb the buffer.
    write_word(2400, 16'hDEAD);
    write_word(4095, 16'hBEEF);
    chk("oob_set", 32'(oob_write), 32'd1);
    fetch_row(29, 2, -1, -1);
    chk("oob_sticky", 32'(oob_write), 32'd1);

    // Illegal row: straight to done, nothing streamed.
    row_req = 1'b1;
    row_idx = 5'd30;
    tick();
    row_req = 1'b0;
    chk("badrow_done", 32'(row_done), 32'd1);
    chk("badrow_busy", 32'(row_busy), 32'd0);
    chk("badrow_valid", 32'(cell_valid), 32'd0);
    tick();
    chk("badrow_done_clear", 32'(row_done), 32'd0);
    chk("badrow_idle", {30'd0, row_busy, cell_valid}, 32'd0);

    // Same-cycle write to the cell being read.
    fetch_row(5, 0, 5, -1);
    fetch_row(5, 2, -1, -1);

    // Reset mid-row, then a clean refetch.
    fetch_row(0, 0, -1, 10);
    chk("oob_cleared_by_rst", 32'(oob_write), 32'd0);
    fetch_row(0, 2, -1, -1);

    // Random rows with fresh random contents.
    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(0, TB_ROWS - 1);
      fill_row(r, 0);
      fetch_row(r, $urandom_range(0, 2), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
